// File: rtl/a2d_rr_sched.sv
// ---------------------------------------------------------------------------
// a2d_rr_sched
// Round-robin conversion scheduler for the A2D path (ADC128S behind one SPI
// master). Three slots share the SPI master: slot0 left load cell, slot1
// right load cell, slot2 battery. Each nxt request runs the ADC128S
// two-transaction sequence for the current slot: the first transaction sends
// the channel, the second reads back the conversion. The 12-bit result is
// latched into the slot's register and the slot pointer advances. A WAIT
// state that sees no spi_done for TO_CYC cycles aborts and sets sticky err.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   nxt             request conversion of current slot (ignored unless IDLE)
//   clr_err         clears sticky err (a new timeout in the same clk wins)
//   spi_wrt         1-clk pulse starting an SPI transaction
//   spi_cmd         {2'b00, ch, 11'h000}, held until the next spi_wrt
//   spi_done        SPI transaction complete (1-clk pulse)
//   spi_rd_data     data returned by the last SPI transaction
//   lft_ld/rght_ld/batt  latest results of slots 0/1/2
//   vld, vld_slot   1-clk pulse and slot index when a result register updates
//   busy            high in every state except IDLE
//   err             sticky transaction-timeout flag
// ---------------------------------------------------------------------------
module a2d_rr_sched #(
  parameter logic [2:0] CH_LFT  = 3'd0,
  parameter logic [2:0] CH_RGHT = 3'd4,
  parameter logic [2:0] CH_BATT = 3'd5,
  parameter int         TO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        clr_err,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        vld,
  output logic [1:0]  vld_slot,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CH_WR   = 3'd1;
  localparam logic [2:0] CH_WAIT = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] RD_WR   = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;

  // one spare bit so TO_CYC-1 is always representable
  localparam int CNT_W = $clog2(TO_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [1:0]       ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_s;
  logic             abort_s;
  logic             cnt_exp_s;
  logic             rd_hi_unused_s;

  logic             spi_wrt_r;
  logic [15:0]      spi_cmd_r;
  logic [11:0]      lft_ld_r;
  logic [11:0]      rght_ld_r;
  logic [11:0]      batt_r;
  logic             vld_r;
  logic [1:0]       vld_slot_r;
  logic             busy_r;
  logic             err_r;

  // ADC channel served by a slot
  function automatic logic [2:0] slot_ch(input logic [1:0] slot);
    case (slot)
      2'd0:    slot_ch = CH_LFT;
      2'd1:    slot_ch = CH_RGHT;
      default: slot_ch = CH_BATT;
    endcase
  endfunction

  // upper nibble of the ADC frame carries no conversion data
  assign rd_hi_unused_s = ^spi_rd_data[15:12];
  assign cnt_exp_s      = (cnt_r == CNT_LAST);

  // next-state logic; spi_done takes priority over an expiring counter
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (nxt) state_s = CH_WR;
        else     state_s = IDLE;
      end
      CH_WR: state_s = CH_WAIT;
      CH_WAIT: begin
        if (spi_done) begin
          state_s = GAP;
        end else if (cnt_exp_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = CH_WAIT;
        end
      end
      GAP:   state_s = RD_WR;
      RD_WR: state_s = RD_WAIT;
      RD_WAIT: begin
        if (spi_done) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else if (cnt_exp_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = RD_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state register; busy tracks the state being entered so it is registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // timeout counter: cleared while launching, counts while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_r == CH_WR) || (state_r == RD_WR)) begin
      cnt_r <= '0;
    end else if ((state_r == CH_WAIT) || (state_r == RD_WAIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // SPI launch pulse and command word (command loaded once per request)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_wrt_r <= 1'b0;
      spi_cmd_r <= 16'h0000;
    end else begin
      spi_wrt_r <= (state_r == CH_WR) || (state_r == RD_WR);
      if ((state_r == IDLE) && nxt) spi_cmd_r <= {2'b00, slot_ch(ptr_r), 11'h000};
      else                          spi_cmd_r <= spi_cmd_r;
    end
  end

  // result capture, valid strobe and slot pointer; aborts change none of them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= 2'd0;
      lft_ld_r   <= 12'h000;
      rght_ld_r  <= 12'h000;
      batt_r     <= 12'h000;
      vld_r      <= 1'b0;
      vld_slot_r <= 2'd0;
    end else begin
      vld_r <= done_s;
      if (done_s) begin
        vld_slot_r <= ptr_r;
        case (ptr_r)
          2'd0:    lft_ld_r  <= spi_rd_data[11:0];
          2'd1:    rght_ld_r <= spi_rd_data[11:0];
          default: batt_r    <= spi_rd_data[11:0];
        endcase
        ptr_r <= (ptr_r == 2'd2) ? 2'd0 : ptr_r + 2'd1;
      end else begin
        vld_slot_r <= vld_slot_r;
        ptr_r      <= ptr_r;
      end
    end
  end

  // sticky timeout flag; a new timeout beats a concurrent clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (abort_s) begin
      err_r <= 1'b1;
    end else if (clr_err) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign spi_wrt  = spi_wrt_r;
  assign spi_cmd  = spi_cmd_r;
  assign lft_ld   = lft_ld_r;
  assign rght_ld  = rght_ld_r;
  assign batt     = batt_r;
  assign vld      = vld_r;
  assign vld_slot = vld_slot_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule
